// File: rtl/animation_sequencer.sv
// Frame-rate sprite animation scheduler: steps bitmap frame and horizontal position every N display frames.
// Optional ANIM_BOB_EN: sprite_top bobs by 8 pixels on odd animation frames.
module animation_sequencer #(
  parameter int unsigned X_BITS      = 10,
  parameter int unsigned X_LIMIT     = 640,
  parameter int unsigned FRAME_BITS  = 1,
  parameter int unsigned NUM_FRAMES  = 2,
  parameter int unsigned LEFT_INIT   = 128,
  parameter int unsigned TOP_BASE    = 128,
  parameter int unsigned PERIOD_INIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [4:0]            cfg_period,
  input  logic [3:0]            cfg_dx,
  input  logic                  cfg_run,
  output logic [FRAME_BITS-1:0] frame_sel,
  output logic [X_BITS-1:0]     sprite_left,
  output logic [9:0]            sprite_top,
  output logic                  advance
);

  localparam int unsigned SUM_W = X_BITS + 1;
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_STOP = 1'b1;
  localparam logic signed [SUM_W-1:0] LIMIT_S = SUM_W'(X_LIMIT);

  logic [0:0]            state_q, state_d;
  logic [4:0]            period_q, period_d;
  logic [3:0]            dx_q, dx_d;
  logic [4:0]            tick_q, tick_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [X_BITS-1:0]     left_q, left_d;
  logic                  adv_q, adv_d;

  logic                    xfer;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] wrapped;

  assign cfg_ready = frame_start && !rst;
  assign xfer      = cfg_valid && cfg_ready;

  // Horizontal step with modular wrap into 0..X_LIMIT-1
  always_comb begin
    sum     = $signed({1'b0, left_q}) + SUM_W'($signed(dx_q));
    wrapped = sum;
    if (sum >= LIMIT_S) begin
      wrapped = sum - LIMIT_S;
    end else if (sum[SUM_W-1]) begin
      wrapped = sum + LIMIT_S;
    end
  end

  // Step uses the registered (old) dx/period; an accepted config only affects later frames
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    dx_d     = dx_q;
    tick_d   = tick_q;
    frame_d  = frame_q;
    left_d   = left_q;
    adv_d    = 1'b0;

    if ((state_q == ST_RUN) && frame_start) begin
      if (tick_q == (period_q - 5'd1)) begin
        tick_d  = '0;
        frame_d = (frame_q == FRAME_BITS'(NUM_FRAMES - 1)) ? '0 : frame_q + FRAME_BITS'(1);
        left_d  = X_BITS'(wrapped);
        adv_d   = 1'b1;
      end else begin
        tick_d = tick_q + 5'd1;
      end
    end

    if (xfer) begin
      state_d  = cfg_run ? ST_RUN : ST_STOP;
      period_d = (cfg_period == 5'd0) ? 5'd1 : cfg_period;
      dx_d     = cfg_dx;
      tick_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      period_q <= 5'(PERIOD_INIT);
      dx_q     <= '0;
      tick_q   <= '0;
      frame_q  <= '0;
      left_q   <= X_BITS'(LEFT_INIT);
      adv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      dx_q     <= dx_d;
      tick_q   <= tick_d;
      frame_q  <= frame_d;
      left_q   <= left_d;
      adv_q    <= adv_d;
    end
  end

`ifdef ANIM_BOB_EN
  logic [9:0] top_q, top_d;

  always_comb begin
    top_d = frame_d[0] ? 10'(TOP_BASE + 8) : 10'(TOP_BASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= 10'(TOP_BASE);
    end else begin
      top_q <= top_d;
    end
  end

  assign sprite_top = top_q;
`else
  assign sprite_top = 10'(TOP_BASE);
`endif

  assign frame_sel   = frame_q;
  assign sprite_left = left_q;
  assign advance     = adv_q;

endmodule

// File: tb/tb_animation_sequencer.sv
// Scoreboard bench for animation_sequencer: directed frame pulses and configs, expected steps queued up front.
module tb_animation_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] cfg_period;
  logic [3:0] cfg_dx;
  logic       cfg_run;
  logic [0:0] frame_sel;
  logic [9:0] sprite_left;
  logic [9:0] sprite_top;
  logic       advance;

  typedef struct packed {
    logic [0:0] fs;
    logic [9:0] left;
    logic [9:0] top;
  } exp_t;

`ifdef ANIM_BOB_EN
  localparam logic [9:0] TOP1 = 10'd136;
`else
  localparam logic [9:0] TOP1 = 10'd128;
`endif

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  animation_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_dx      (cfg_dx),
    .cfg_run     (cfg_run),
    .frame_sel   (frame_sel),
    .sprite_left (sprite_left),
    .sprite_top  (sprite_top),
    .advance     (advance)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int fs, input int left);
    exp_t e;
    e.fs   = 1'(fs);
    e.left = 10'(left);
    e.top  = (fs != 0) ? TOP1 : 10'd128;
    exp_q.push_back(e);
  endtask

  task automatic pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cfg_pulse(input int per, input int dx, input int run);
    @(negedge clk);
    cfg_valid   = 1'b1;
    cfg_period  = 5'(per);
    cfg_dx      = 4'(dx);
    cfg_run     = 1'(run);
    frame_start = 1'b1;
    #1;
    check("cfg_ready_on_pulse", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every advance pulse must match the oldest queued step
  always @(negedge clk) begin
    exp_t e;
    if (advance) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_advance: got advance with frame_sel=%0d sprite_left=%0d, required no advance",
                 frame_sel, sprite_left);
      end else begin
        e = exp_q.pop_front();
        check("step_frame_sel", 32'(frame_sel), 32'(e.fs));
        check("step_sprite_left", 32'(sprite_left), 32'(e.left));
        check("step_sprite_top", 32'(sprite_top), 32'(e.top));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int ready_hi;
    rst         = 1'b1;
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    cfg_period  = '0;
    cfg_dx      = '0;
    cfg_run     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_frame_sel", 32'(frame_sel), 32'd0);
    check("rst_sprite_left", 32'(sprite_left), 32'd128);
    check("rst_sprite_top", 32'(sprite_top), 32'd128);
    check("rst_advance", 32'(advance), 32'd0);
    frame_start = 1'b1;
    #1;
    check("cfg_ready_in_rst", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Default period 16, dx 0
    for (int p = 1; p <= 32; p++) begin
      if (p == 16) push(1, 128);
      if (p == 32) push(0, 128);
      pulse();
    end

    // Period 2, dx +7
    cfg_pulse(2, 7, 1);
    pulse();
    push(1, 135);
    pulse();
    pulse();
    push(0, 142);
    pulse();

    // Config on step pulses: each step uses the previous dx
    pulse();
    push(1, 149);
    cfg_pulse(0, -5, 1);
    push(0, 144);
    cfg_pulse(0, -8, 1);
    for (int i = 1; i <= 17; i++) begin
      push(i % 2, 144 - 8 * i);
      pulse();
    end
    push(0, 0);
    cfg_pulse(0, 4, 1);
    push(1, 4);
    cfg_pulse(0, -8, 1);
    push(0, 636);
    cfg_pulse(0, 7, 1);
    push(1, 3);
    pulse();
    check("queue_drained_running", 32'(exp_q.size()), 32'd0);

    // Pending request without frame_start
    @(negedge clk);
    cfg_valid  = 1'b1;
    cfg_period = 5'd0;
    cfg_dx     = 4'd0;
    cfg_run    = 1'b0;
    ready_hi   = 0;
    repeat (100) begin
      @(negedge clk);
      if (cfg_ready) ready_hi++;
    end
    check("ready_low_while_pending", 32'(ready_hi), 32'd0);
    push(0, 10);
    cfg_pulse(0, 0, 0);

    // Stopped: no steps, outputs frozen
    repeat (20) pulse();
    check("stopped_frame_sel", 32'(frame_sel), 32'd0);
    check("stopped_sprite_left", 32'(sprite_left), 32'd10);
    check("stopped_sprite_top", 32'(sprite_top), 32'd128);

    // Reset on a transfer pulse wins
    @(negedge clk);
    rst         = 1'b1;
    frame_start = 1'b1;
    cfg_valid   = 1'b1;
    cfg_period  = 5'd0;
    cfg_dx      = 4'd7;
    cfg_run     = 1'b1;
    #1;
    check("cfg_ready_rst_pulse", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    rst         = 1'b0;
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    check("rst2_frame_sel", 32'(frame_sel), 32'd0);
    check("rst2_sprite_left", 32'(sprite_left), 32'd128);
    check("rst2_sprite_top", 32'(sprite_top), 32'd128);
    check("rst2_advance", 32'(advance), 32'd0);
    for (int p = 1; p <= 16; p++) begin
      if (p == 16) push(1, 128);
      pulse();
    end

    repeat (3) @(negedge clk);
    check("queue_drained_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
